i2c_scl_phase_gen: RTL and testbench

//  Parametrised I2C SCL timing generator; next generation of the fixed-ratio I2C clock divider.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_scl_phase_gen_if.sv | 29 ++
 rtl/i2c_qtr_counter.sv | 38 +++
 rtl/i2c_scl_phase_gen.sv | 137 +++++++++++++
 tb/tb_i2c_scl_phase_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL phase encoding and divisor limits used by the
// SCL phase generator and the byte/bit controller.
package i2c_pkg;

  localparam int unsigned I2C_CNT_W = 16;
  localparam int unsigned MIN_QDIV  = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO1  = 3'd1,
    LO2  = 3'd2,
    HI1  = 3'd3,
    HI2  = 3'd4
  } phase_e;

endpackage

// File: rtl/i2c_scl_phase_gen_if.sv
// Controller-side bundle of the SCL phase generator: run/divisor controls,
// bus SCL level, and the SCL drive level plus timing strobes.
interface i2c_scl_phase_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             scl_in;
  logic             scl_out;
  logic             scl_fall_stb;
  logic             scl_rise_stb;
  logic             sda_chg_stb;
  logic             sda_smp_stb;
  logic             busy;
  logic             stretching;

  modport master (
    output en, div_load, div_val, scl_in,
    input  scl_out, scl_fall_stb, scl_rise_stb, sda_chg_stb, sda_smp_stb,
           busy, stretching
  );

  modport slave (
    input  en, div_load, div_val, scl_in,
    output scl_out, scl_fall_stb, scl_rise_stb, sda_chg_stb, sda_smp_stb,
           busy, stretching
  );
endinterface

// File: rtl/i2c_qtr_counter.sv
// Quarter-period counter: counts 0..q-1 with q = max(div, MIN_QDIV),
// flags the terminal count, and can be frozen by a hold request.
module i2c_qtr_counter
  import i2c_pkg::*;
#(
  parameter int unsigned CNT_W = I2C_CNT_W
) (
  input  logic             REF_CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             hold,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  logic [CNT_W-1:0] q_eff;

  // Divisors below the minimum would give a zero-length or single-cycle phase.
  always_comb begin
    q_eff = div;
    if (div < CNT_W'(MIN_QDIV)) begin
      q_eff = CNT_W'(MIN_QDIV);
    end
    tc_c = run && !hold && (cnt == (q_eff - CNT_W'(1)));
  end

  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (!run || tc_c) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_scl_phase_gen.sv
// I2C SCL timing generator: four-phase SCL FSM with programmable quarter period
// and single-cycle edge/SDA strobes. Optional slave clock stretching under
// macro I2C_SCL_STRETCH_EN.
module i2c_scl_phase_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CNT_W        = I2C_CNT_W,
  parameter int unsigned DEFAULT_QDIV = 250
) (
  input  logic                 REF_CLK,
  input  logic                 RESET,
  i2c_scl_phase_gen_if.slave   bus
);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] shadow_q, active_q;
  logic [CNT_W-1:0] cnt;
  logic             tc_c;
  logic             hold_c;
  logic             load_active_c;

  logic scl_q, scl_d;
  logic fall_q, fall_d;
  logic rise_q, rise_d;
  logic chg_q, chg_d;
  logic smp_q, smp_d;
  logic busy_q;
  logic stretch_q;

`ifdef I2C_SCL_STRETCH_EN
  // First HI1 cycle is skipped so the bus has time to rise after release.
  assign hold_c = (state_q == HI1) && (cnt != '0) && !bus.scl_in;
`else
  assign hold_c = 1'b0;
`endif

  i2c_qtr_counter #(
    .CNT_W (CNT_W)
  ) u_qtr_counter (
    .REF_CLK (REF_CLK),
    .RESET   (RESET),
    .run     (state_q != IDLE),
    .hold    (hold_c),
    .div     (active_q),
    .cnt     (cnt),
    .tc_c    (tc_c)
  );

  // Next phase and the output values that take effect on phase entry.
  always_comb begin
    state_d       = state_q;
    scl_d         = scl_q;
    fall_d        = 1'b0;
    rise_d        = 1'b0;
    chg_d         = 1'b0;
    smp_d         = 1'b0;
    load_active_c = 1'b0;
    case (state_q)
      IDLE: begin
        scl_d = 1'b1;
        if (bus.en) begin
          state_d       = LO1;
          scl_d         = 1'b0;
          fall_d        = 1'b1;
          load_active_c = 1'b1;
        end
      end
      LO1: if (tc_c) begin
        state_d = LO2;
        chg_d   = 1'b1;
      end
      LO2: if (tc_c) begin
        state_d = HI1;
        scl_d   = 1'b1;
        rise_d  = 1'b1;
      end
      HI1: if (tc_c) begin
        state_d = HI2;
        smp_d   = 1'b1;
      end
      HI2: if (tc_c) begin
        if (bus.en) begin
          state_d       = LO1;
          scl_d         = 1'b0;
          fall_d        = 1'b1;
          load_active_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        scl_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shadow_q  <= CNT_W'(DEFAULT_QDIV);
      active_q  <= CNT_W'(DEFAULT_QDIV);
      scl_q     <= 1'b1;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
      chg_q     <= 1'b0;
      smp_q     <= 1'b0;
      busy_q    <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      fall_q    <= fall_d;
      rise_q    <= rise_d;
      chg_q     <= chg_d;
      smp_q     <= smp_d;
      busy_q    <= (state_d != IDLE);
      stretch_q <= hold_c;
      if (bus.div_load) begin
        shadow_q <= bus.div_val;
      end
      // Active reads the pre-write shadow, so a coincident load waits a period.
      if (load_active_c) begin
        active_q <= shadow_q;
      end
    end
  end

  assign bus.scl_out      = scl_q;
  assign bus.scl_fall_stb = fall_q;
  assign bus.scl_rise_stb = rise_q;
  assign bus.sda_chg_stb  = chg_q;
  assign bus.sda_smp_stb  = smp_q;
  assign bus.busy         = busy_q;
  assign bus.stretching   = stretch_q;

endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// Scoreboard bench for i2c_scl_phase_gen (DEFAULT_QDIV=4); honours I2C_SCL_STRETCH_EN.
module tb_i2c_scl_phase_gen;

  localparam int unsigned CNT_W = 16;
  localparam int K_FALL = 0;
  localparam int K_CHG  = 1;
  localparam int K_RISE = 2;
  localparam int K_SMP  = 3;
`ifdef I2C_SCL_STRETCH_EN
  localparam int S = 6;
`else
  localparam int S = 0;
`endif

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic REF_CLK = 1'b0;
  logic RESET   = 1'b1;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;
  int   stretch_cnt = 0;
  ev_t  exp_q[$];

  i2c_scl_phase_gen_if #(.CNT_W(CNT_W)) bus ();

  i2c_scl_phase_gen #(
    .CNT_W        (CNT_W),
    .DEFAULT_QDIV (4)
  ) dut (
    .REF_CLK (REF_CLK),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 REF_CLK = ~REF_CLK;
  always @(posedge REF_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push_period(input int base, input int q, input int s);
    push(K_FALL, base);
    push(K_CHG,  base + q);
    push(K_RISE, base + 2*q);
    push(K_SMP,  base + 3*q + s);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge REF_CLK);
  endtask

  task automatic load(input int v);
    bus.div_load = 1'b1;
    bus.div_val  = CNT_W'(v);
    @(negedge REF_CLK);
    bus.div_load = 1'b0;
  endtask

  function automatic int out_vec();
    return int'({bus.scl_out, bus.busy, bus.stretching, bus.scl_fall_stb,
                 bus.scl_rise_stb, bus.sda_chg_stb, bus.sda_smp_stb});
  endfunction

  // Monitor: every presented strobe is popped against the scoreboard.
  always @(negedge REF_CLK) begin
    int  n;
    int  k;
    ev_t e;
    n = 0;
    k = -1;
    if (bus.scl_fall_stb === 1'b1) begin n++; k = K_FALL; end
    if (bus.sda_chg_stb  === 1'b1) begin n++; k = K_CHG;  end
    if (bus.scl_rise_stb === 1'b1) begin n++; k = K_RISE; end
    if (bus.sda_smp_stb  === 1'b1) begin n++; k = K_SMP;  end
    if (bus.stretching === 1'b1) stretch_cnt++;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      check("missed_strobe_kind_at_cycle", e.kind, -1);
    end
    if (n > 1) begin
      check("strobes_onehot", n, 1);
    end else if (n == 1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_kind", k, -1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", k, e.kind);
        check("strobe_cycle", cyc, e.at);
        if (k == K_FALL) check("scl_low_at_fall", int'(bus.scl_out), 0);
        if (k == K_RISE) check("scl_high_at_rise", int'(bus.scl_out), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, f, g;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    bus.scl_in   = 1'b1;
    repeat (3) @(negedge REF_CLK);
    check("reset_outputs", out_vec(), 64);
    RESET = 1'b0;
    @(negedge REF_CLK);

    // Default q=4 periods, then div load mid-HI1, clamp of 0, restore 4.
    e = cyc + 1;
    bus.en = 1'b1;
    for (int p = 0; p < 4; p++) push_period(e + 16*p, 4, 0);
    push_period(e + 64,  10, 0);
    push_period(e + 104, 2,  0);
    push_period(e + 112, 4,  0);
    push_period(e + 128, 4,  0);
    wait_until(e + 57);
    load(10);
    wait_until(e + 70);
    load(0);
    wait_until(e + 105);
    load(4);

    // en dropped in LO1: period completes, then IDLE without a strobe.
    wait_until(e + 130);
    check("busy_mid_period", int'(bus.busy), 1);
    bus.en = 1'b0;
    wait_until(e + 146);
    check("idle_scl_out", int'(bus.scl_out), 1);
    check("idle_busy", int'(bus.busy), 0);

    // Reset in LO2 with a pending shadow value of 6.
    wait_until(e + 150);
    f = cyc + 1;
    bus.en = 1'b1;
    push(K_FALL, f);
    push(K_CHG,  f + 4);
    wait_until(f + 1);
    load(6);
    wait_until(f + 5);
    RESET  = 1'b1;
    bus.en = 1'b0;
    @(negedge REF_CLK);
    check("midperiod_reset_outputs", out_vec(), 64);
    @(negedge REF_CLK);
    RESET = 1'b0;

    // Restart: period must use DEFAULT_QDIV; second period has a stretch.
    wait_until(f + 10);
    g = cyc + 1;
    bus.en = 1'b1;
    push_period(g,          4, 0);
    push_period(g + 16,     4, S);
    push_period(g + 32 + S, 4, 0);
    @(negedge REF_CLK);
    stretch_cnt = 0;
    wait_until(g + 25);
    bus.scl_in = 1'b0;
    repeat (6) @(negedge REF_CLK);
    bus.scl_in = 1'b1;
    wait_until(g + 33 + S);
    bus.en = 1'b0;
    wait_until(g + 52 + S);
    check("stretching_cycles", stretch_cnt, S);
    check("final_busy", int'(bus.busy), 0);
    check("final_scl_out", int'(bus.scl_out), 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
